bcd_convert_seq: RTL

// Iterative, parametrised binary-to-BCD converter (shift-add-3), one input bit per clock.

---
 rtl/bcd_convert_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bcd_convert_seq.sv
// Iterative shift-add-3 binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
// Optional macro BCD_SIGNED_EN: treat in_data as two's complement and report the sign on out_neg.
module bcd_convert_seq #(
  parameter  int BIN_W  = 16,
  localparam int DIGITS = (BIN_W * 30103 + 99999) / 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  out_neg,
  output logic                  busy
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [BIN_W-1:0]   shreg, shreg_next, mag;
  logic [ACC_W-1:0]   acc, acc_adj, acc_next;
  logic [CNT_W-1:0]   count;
  logic               accept, last;

  // Digits of 5 or more get +3 before the shift so they carry correctly into the next digit.
  function automatic logic [ACC_W-1:0] add3_fix(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int d = 0; d < DIGITS; d++) begin
      if (a[4*d +: 4] >= 4'd5) r[4*d +: 4] = a[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign accept = in_valid & in_ready;
  assign last   = (state == SHIFT) && (count == CNT_W'(BIN_W - 1));

`ifdef BCD_SIGNED_EN
  logic signed [BIN_W-1:0] in_signed;
  logic                    neg_pend;

  assign in_signed = in_data;
  // -2^(BIN_W-1) wraps to itself, which read as unsigned is the exact magnitude.
  assign mag = in_signed[BIN_W-1] ? $unsigned(-in_signed) : $unsigned(in_signed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_pend <= 1'b0;
      out_neg  <= 1'b0;
    end else begin
      if (accept) neg_pend <= in_signed[BIN_W-1];
      if (last)   out_neg  <= neg_pend;
    end
  end
`else
  assign mag     = in_data;
  assign out_neg = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last)   state_next = DONE;
      DONE:    if (out_ready) state_next = in_valid ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    busy      = (state == SHIFT);
    out_valid = (state == DONE);
  end

  // Shift datapath
  always_comb begin
    acc_adj    = add3_fix(acc);
    acc_next   = (acc_adj << 1) | ACC_W'(shreg[BIN_W-1]);
    shreg_next = shreg << 1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= mag;
      acc   <= '0;
    end else if (state == SHIFT) begin
      shreg <= shreg_next;
      acc   <= acc_next;
    end
  end

  // Count and result register; bcd only changes on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      bcd   <= '0;
    end else if (accept) begin
      count <= '0;
    end else if (state == SHIFT) begin
      count <= count + CNT_W'(1);
      if (last) bcd <= acc_next;
    end
  end

endmodule
